instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_queue.sv | 52 +++++
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package instr_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one edge.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push && (count < DEPTH_C);
  assign do_pop     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; head_data is masked to zero while empty, so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory request, redirect handling, and a decode queue.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic            issue;
  logic            push;
  logic [CW-1:0]   count;
  fetch_entry_t    push_entry, head_entry;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect_valid && count < DEPTH_C) begin
          state_d = BUSY;
          issue   = 1'b1;
        end
      end
      BUSY: begin
        if (imem_ack) begin
          state_d = IDLE;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_next = pc;
    if (!reset) begin
      if (redirect_valid)
        pc_next = {redirect_target[XLEN-1:2], 2'b00};
      else if (push)
        pc_next = pc + XLEN'(INSTR_BYTES);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state_q  <= state_d;
      imem_req <= (state_d != IDLE);
      if (issue) imem_addr <= pc;
    end
  end

  assign push_entry = '{pc: imem_addr, instr: imem_rdata};

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (dec_ready),
    .flush      (redirect_valid),
    .head_valid (dec_valid),
    .head_data  (head_entry),
    .count      (count)
  );

  assign dec_instr = head_entry.instr;
  assign dec_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus hand-written redirect/wrap/reset sequences.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .dec_valid       (dec_valid),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_ready       (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc_init;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] exp_pc_next;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_dv;
    logic [31:0] exp_dpc;
    logic [31:0] exp_dinstr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [31:0] pc_init, logic ack, logic [31:0] rdata,
                              logic ready, logic [31:0] epn, logic ereq, logic [31:0] eaddr,
                              logic edv, logic [31:0] edpc, logic [31:0] edi);
    vec_t v;
    v.rst = rst; v.pc_init = pc_init; v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.exp_pc_next = epn; v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_dv = edv; v.exp_dpc = edpc; v.exp_dinstr = edi;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Models the external PC register: pc follows pc_next at every rising edge.
  task automatic tick();
    logic [31:0] nxt;
    nxt = pc_next;
    @(posedge clk);
    #1;
    pc = nxt;
  endtask

  task automatic do_reset(input logic [31:0] pc_init);
    reset = 1'b1; redirect_valid = 1'b0; imem_ack = 1'b0; dec_ready = 1'b0;
    pc = pc_init;
    #1;
    check("reset_pc_next", pc_next, pc_init);
    tick();
    check("reset_req", {31'b0, imem_req}, 32'd0);
    check("reset_dv", {31'b0, dec_valid}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc = '0; redirect_valid = 1'b0; redirect_target = '0;
    imem_ack = 1'b0; imem_rdata = '0; dec_ready = 1'b0;

    // Sequential fetch with decode always ready: addr 0,4,8.
    vecs.push_back(mk(1, 32'h0, 0, 32'h0,        1, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 0, 32'h0,        1, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 1, 32'hA0A0A0A0, 1, 32'h4, 0, 32'h0, 1, 32'h0, 32'hA0A0A0A0));
    vecs.push_back(mk(0, 32'h0, 0, 32'h0,        1, 32'h4, 1, 32'h4, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 1, 32'hA1A1A1A1, 1, 32'h8, 0, 32'h4, 1, 32'h4, 32'hA1A1A1A1));
    vecs.push_back(mk(0, 32'h0, 0, 32'h0,        1, 32'h8, 1, 32'h8, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 1, 32'hA2A2A2A2, 1, 32'hC, 0, 32'h8, 1, 32'h8, 32'hA2A2A2A2));
    // Decode stalled: queue fills to DEPTH, no further request, then drains.
    vecs.push_back(mk(1, 32'h0, 0, 32'h0,        0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 0, 32'h0,        0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 1, 32'h11110000, 0, 32'h4, 0, 32'h0, 1, 32'h0, 32'h11110000));
    vecs.push_back(mk(0, 32'h0, 0, 32'h0,        0, 32'h4, 1, 32'h4, 1, 32'h0, 32'h11110000));
    vecs.push_back(mk(0, 32'h0, 1, 32'h22220004, 0, 32'h8, 0, 32'h4, 1, 32'h0, 32'h11110000));
    vecs.push_back(mk(0, 32'h0, 0, 32'h0,        0, 32'h8, 0, 32'h4, 1, 32'h0, 32'h11110000));
    vecs.push_back(mk(0, 32'h0, 0, 32'h0,        0, 32'h8, 0, 32'h4, 1, 32'h0, 32'h11110000));
    vecs.push_back(mk(0, 32'h0, 0, 32'h0,        1, 32'h8, 0, 32'h4, 1, 32'h4, 32'h22220004));
    vecs.push_back(mk(0, 32'h0, 0, 32'h0,        1, 32'h8, 1, 32'h8, 0, 32'h0, 32'h0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      dec_ready = vecs[i].ready; redirect_valid = 1'b0;
      if (vecs[i].rst) pc = vecs[i].pc_init;
      #1;
      check($sformatf("v%0d_pc_next", i), pc_next, vecs[i].exp_pc_next);
      tick();
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_dv", i), {31'b0, dec_valid}, {31'b0, vecs[i].exp_dv});
      if (vecs[i].exp_dv || vecs[i].rst) begin
        check($sformatf("v%0d_dpc", i), dec_pc, vecs[i].exp_dpc);
        check($sformatf("v%0d_dinstr", i), dec_instr, vecs[i].exp_dinstr);
      end
    end

    // Redirect while BUSY with a queued entry: queue flushed, late word dropped.
    do_reset(32'h40);
    imem_ack = 0; #1; tick();
    check("rd_req1", {31'b0, imem_req}, 32'd1);
    check("rd_addr1", imem_addr, 32'h40);
    imem_ack = 1; imem_rdata = 32'h11; #1;
    check("rd_pc_next_push", pc_next, 32'h44);
    tick();
    check("rd_dpc", dec_pc, 32'h40);
    check("rd_dinstr", dec_instr, 32'h11);
    imem_ack = 0; #1; tick();
    check("rd_addr2", imem_addr, 32'h44);
    redirect_valid = 1; redirect_target = 32'h103; dec_ready = 1; #1;
    check("rd_pc_next_tgt", pc_next, 32'h100);
    tick();
    check("rd_flushed_dv", {31'b0, dec_valid}, 32'd0);
    check("rd_flush_req", {31'b0, imem_req}, 32'd1);
    redirect_valid = 0; dec_ready = 0; #1; tick();
    check("rd_flush_addr", imem_addr, 32'h44);
    imem_ack = 1; imem_rdata = 32'h22; #1;
    check("rd_drop_pc_next", pc_next, 32'h100);
    tick();
    check("rd_drop_dv", {31'b0, dec_valid}, 32'd0);
    check("rd_drop_req", {31'b0, imem_req}, 32'd0);
    imem_ack = 0; #1; tick();
    check("rd_new_req", {31'b0, imem_req}, 32'd1);
    check("rd_new_addr", imem_addr, 32'h100);

    // Ack and redirect in the same cycle while BUSY: no push, straight to IDLE.
    imem_ack = 1; imem_rdata = 32'h33; redirect_valid = 1; redirect_target = 32'h200; #1;
    check("same_pc_next", pc_next, 32'h200);
    tick();
    check("same_dv", {31'b0, dec_valid}, 32'd0);
    check("same_req", {31'b0, imem_req}, 32'd0);
    imem_ack = 0; redirect_valid = 0; #1; tick();
    check("same_reissue_addr", imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    do_reset(32'hFFFF_FFFC);
    #1; tick();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1; imem_rdata = 32'h44; #1;
    check("wrap_pc_next", pc_next, 32'h0);
    tick();
    check("wrap_dpc", dec_pc, 32'hFFFF_FFFC);
    check("wrap_dinstr", dec_instr, 32'h44);
    imem_ack = 0;

    // Reset mid-BUSY, then a late ack: ignored.
    do_reset(32'h80);
    #1; tick();
    check("rst_busy_req", {31'b0, imem_req}, 32'd1);
    reset = 1; redirect_valid = 1; redirect_target = 32'h500; #1;
    check("rst_pc_next_hold", pc_next, 32'h80);
    tick();
    check("rst_req0", {31'b0, imem_req}, 32'd0);
    check("rst_addr0", imem_addr, 32'h0);
    reset = 0; redirect_valid = 0; imem_ack = 1; imem_rdata = 32'h55; #1;
    check("late_ack_pc_next", pc_next, 32'h80);
    tick();
    check("late_ack_dv", {31'b0, dec_valid}, 32'd0);
    check("late_ack_addr", imem_addr, 32'h80);
    imem_ack = 0; #1; tick();
    check("late_ack_dv2", {31'b0, dec_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
